// File: rtl/fdtd_pkg.sv
`default_nettype none
//============================================================
// fdtd_pkg: shared FSM state type and Q-format constants.
// Rev 1.0
//============================================================
package fdtd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fdtd_state_t;

    localparam int FRAC_BITS  = 16;
    localparam int DEF_DATA_W = 32;

    // Saturation bounds for the default field width.
    localparam logic signed [DEF_DATA_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [DEF_DATA_W-1:0] SAT_MIN = 32'sh8000_0000;

endpackage
`default_nettype wire

// File: rtl/fdtd_mac_pipe.sv
`default_nettype none
//============================================================
// fdtd_mac_pipe: 3-stage ca*E + cb*(H[k]-H[k-1]) with saturation.
// Rev 1.0
//============================================================
module fdtd_mac_pipe
    import fdtd_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clr,
    input  logic              stall,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] ca,
    input  logic [DATA_W-1:0] cb,
    input  logic [DATA_W-1:0] e_in,
    input  logic [DATA_W-1:0] h_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] e_out
);

    localparam int PROD_W = 2 * DATA_W + 1;
    localparam int SUM_W  = PROD_W + 1;

    localparam logic signed [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0]  HI    = SUM_W'(MAX_D);
    localparam logic signed [SUM_W-1:0]  LO    = SUM_W'(MIN_D);

    logic signed [DATA_W-1:0] h_prev;
    logic signed [DATA_W-1:0] e_s1;
    logic signed [DATA_W:0]   diff_s1;
    logic                     v1;
    logic signed [PROD_W-1:0] pa_s2;
    logic signed [PROD_W-1:0] pb_s2;
    logic                     v2;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_sh;
    logic signed [DATA_W-1:0] sat;

    // H[k-1] only advances with an accepted cell; a new sweep restarts at the PEC wall.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_prev <= '0;
        end else if (clr) begin
            h_prev <= '0;
        end else if (in_valid && !stall) begin
            h_prev <= $signed(h_in);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v1      <= 1'b0;
            e_s1    <= '0;
            diff_s1 <= '0;
            v2      <= 1'b0;
            pa_s2   <= '0;
            pb_s2   <= '0;
            out_valid <= 1'b0;
            e_out   <= '0;
        end else if (!stall) begin
            v1      <= in_valid;
            e_s1    <= $signed(e_in);
            diff_s1 <= (DATA_W+1)'($signed(h_in)) - (DATA_W+1)'(h_prev);
            v2      <= v1;
            pa_s2   <= PROD_W'($signed(ca)) * PROD_W'(e_s1);
            pb_s2   <= PROD_W'($signed(cb)) * PROD_W'(diff_s1);
            out_valid <= v2;
            if (v2) begin
                e_out <= sat;
            end
        end
    end

    always_comb begin
        sum    = SUM_W'(pa_s2) + SUM_W'(pb_s2);
        sum_sh = sum >>> FRAC_BITS;
        if (sum_sh > HI) begin
            sat = MAX_D;
        end else if (sum_sh < LO) begin
            sat = MIN_D;
        end else begin
            sat = sum_sh[DATA_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fdtd_e_update.sv
`default_nettype none
//============================================================
// fdtd_e_update: 1-D FDTD E-field row sweep controller and handshake.
// Rev 1.0
//============================================================
module fdtd_e_update
    import fdtd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  cell_count_i,
    input  logic [DATA_W-1:0] ca_i,
    input  logic [DATA_W-1:0] cb_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] e_i,
    input  logic [DATA_W-1:0] h_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] e_o,
    output logic              busy_o,
    output logic              done_o
);

    fdtd_state_t       state;
    fdtd_state_t       state_nx;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic [DATA_W-1:0] ca_q;
    logic [DATA_W-1:0] cb_q;
    logic              stall;
    logic              start_ok;
    logic              in_fire;
    logic              out_fire;
    logic              last_in;
    logic              last_out;

    assign stall      = out_valid_o && !out_ready_i;
    assign start_ok   = start_i && (state == ST_IDLE);
    assign in_ready_o = (state == ST_RUN) && !stall && (in_cnt < count_q);
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = out_valid_o && out_ready_i;
    assign last_in    = (in_cnt + CNT_W'(1)) == count_q;
    assign last_out   = (out_cnt + CNT_W'(1)) == count_q;
    assign busy_o     = (state == ST_RUN) || (state == ST_DRAIN);
    assign done_o     = (state == ST_DONE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nx = (cell_count_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_fire && last_in) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_fire && last_out) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Coefficients and count are frozen for the whole sweep once accepted in IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (start_ok) begin
            count_q <= cell_count_i;
            ca_q    <= ca_i;
            cb_q    <= cb_i;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (in_fire) begin
                in_cnt <= in_cnt + CNT_W'(1);
            end
            if (out_fire) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end
        end
    end

    fdtd_mac_pipe #(
        .DATA_W (DATA_W)
    ) u_mac_pipe (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .clr       (start_ok),
        .stall     (stall),
        .in_valid  (in_fire),
        .ca        (ca_q),
        .cb        (cb_q),
        .e_in      (e_i),
        .h_in      (h_i),
        .out_valid (out_valid_o),
        .e_out     (e_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_fdtd_e_update.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================
// tb_fdtd_e_update: randomized scoreboard bench for fdtd_e_update.
// Rev 1.0
//============================================================
module tb_fdtd_e_update;
    import fdtd_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] cell_count_i = '0;
    logic [31:0] ca_i = '0;
    logic [31:0] cb_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] e_i = '0;
    logic [31:0] h_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] e_o;
    logic        busy_o;
    logic        done_o;

    fdtd_e_update #(.DATA_W(32), .CNT_W(16)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .start_i      (start_i),
        .cell_count_i (cell_count_i),
        .ca_i         (ca_i),
        .cb_i         (cb_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .e_i          (e_i),
        .h_i          (h_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .e_o          (e_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 CLK = ~CLK;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e_arr[16];
    logic [31:0] h_arr[16];
    int          ov_total = 0;
    int          cyc = 0;
    int          first_in = -1;
    int          first_out = -1;
    bit          track = 0;
    int          done_pulses = 0;
    int          done_len = 0;
    int          done_maxlen = 0;
    int          rdy_mode = 0;
    int          out_idx = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_e = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // E' = floor((ca*E + cb*(H - Hprev)) / 2^16), clipped to the 32-bit signed range.
    function automatic logic [31:0] ref_e(input logic signed [31:0] ca, input logic signed [31:0] cb,
                                          input logic signed [31:0] e, input logic signed [31:0] h,
                                          input logic signed [31:0] hp);
        logic signed [127:0] acc;
        acc = 128'(ca) * 128'(e) + 128'(cb) * (128'(h) - 128'(hp));
        acc = acc >>> FRAC_BITS;
        if (acc > 128'(SAT_MAX)) return SAT_MAX;
        if (acc < 128'(SAT_MIN)) return SAT_MIN;
        return acc[31:0];
    endfunction

    function automatic logic [31:0] rnd_s(input int mag);
        int v;
        v = int'($urandom_range(0, 2 * mag)) - mag;
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = ~out_ready_i;
                default: out_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output transfer and checks stall hold.
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_stall = 0;
            done_len = 0;
        end else begin
            cyc++;
            if (track && first_in < 0 && in_valid_i && in_ready_o) first_in = cyc;
            if (track && first_out < 0 && out_valid_o) first_out = cyc;
            if (prev_stall) begin
                check("stall_valid_held", 64'(out_valid_o), 64'd1);
                check("stall_e_held", 64'(e_o), 64'(prev_e));
            end
            if (out_valid_o) ov_total++;
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got e_o=%0h with no result pending", e_o);
                end else begin
                    logic [31:0] exp;
                    exp = exp_q.pop_front();
                    check($sformatf("e_o[%0d]", out_idx), 64'(e_o), 64'(exp));
                end
                out_idx++;
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_e = e_o;
            if (done_o) begin
                done_len++;
                if (done_len == 1) done_pulses++;
                if (done_len > done_maxlen) done_maxlen = done_len;
            end else begin
                done_len = 0;
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready_o), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
        check({tag, "_e_o"}, 64'(e_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
    endtask

    task automatic pulse_start(input int n, input logic [31:0] ca, input logic [31:0] cb);
        @(posedge CLK);
        #1;
        start_i = 1'b1;
        cell_count_i = 16'(n);
        ca_i = ca;
        cb_i = cb;
        @(posedge CLK);
        #1;
        start_i = 1'b0;
        cell_count_i = 16'($urandom);
        ca_i = $urandom;
        cb_i = $urandom;
    endtask

    task automatic send_cell(input int k, input bit gaps);
        int  guard;
        bit  ok;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
        end
        in_valid_i = 1'b1;
        e_i = e_arr[k];
        h_i = h_arr[k];
        guard = 0;
        ok = 0;
        while (!ok && guard < 300) begin
            @(negedge CLK);
            ok = in_ready_o;
            guard++;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL in_accept_timeout: cell %0d not accepted in %0d cycles", k, guard);
        end
        @(posedge CLK);
        #1;
        in_valid_i = 1'b0;
        e_i = $urandom;
        h_i = $urandom;
    endtask

    task automatic wait_done(input string tag);
        int guard;
        bit seen;
        guard = 0;
        seen = 0;
        while (!seen && guard < 1000) begin
            @(negedge CLK);
            if (done_o) seen = 1;
            guard++;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_busy_in_done"}, 64'(busy_o), 64'd0);
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        @(negedge CLK);
        check({tag, "_done_one_cycle"}, 64'(done_o), 64'd0);
    endtask

    task automatic run_sweep(input string tag, input int n, input logic [31:0] ca, input logic [31:0] cb,
                             input bit gaps, input bit inj_start);
        logic [31:0] hp;
        int dp0;
        int ov0;
        hp = '0;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(ref_e(ca, cb, e_arr[k], h_arr[k], hp));
            hp = h_arr[k];
        end
        dp0 = done_pulses;
        ov0 = ov_total;
        pulse_start(n, ca, cb);
        check({tag, "_busy_after_start"}, 64'(busy_o), 64'(n > 0));
        for (int k = 0; k < n; k++) begin
            send_cell(k, gaps);
            if (inj_start && k == 0) begin
                start_i = 1'b1;
                cell_count_i = 16'd2;
                ca_i = $urandom;
                cb_i = $urandom;
                @(posedge CLK);
                #1;
                start_i = 1'b0;
            end
        end
        wait_done(tag);
        check({tag, "_done_pulses"}, 64'(done_pulses - dp0), 64'd1);
        if (n == 0) check({tag, "_no_out_valid"}, 64'(ov_total - ov0), 64'd0);
    endtask

    initial begin
        int ov0;
        repeat (3) @(posedge CLK);
        #1;
        check_zero_outputs("reset");
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Basic sweep: E=0, H=1..4, expect 0.5 each with a 3-cycle latency.
        for (int k = 0; k < 4; k++) begin
            e_arr[k] = '0;
            h_arr[k] = 32'((k + 1) << 16);
        end
        track = 1;
        run_sweep("basic", 4, 32'h0001_0000, 32'h0000_8000, 0, 0);
        track = 0;
        check("latency", 64'(first_out - first_in), 64'd3);

        rdy_mode = 1;
        run_sweep("toggle", 4, 32'h0001_0000, 32'h0000_8000, 0, 0);
        rdy_mode = 0;

        e_arr[0] = 32'h7FFF_0000;
        run_sweep("sat_pos", 1, 32'h7FFF_0000, 32'h0, 0, 0);
        e_arr[0] = 32'h8001_0000;
        run_sweep("sat_neg", 1, 32'h7FFF_0000, 32'h0, 0, 0);
        e_arr[0] = '0;
        h_arr[0] = 32'h7FFF_FFFF;
        e_arr[1] = '0;
        h_arr[1] = 32'h8000_0000;
        run_sweep("sat_diff", 2, 32'h0001_0000, 32'h7FFF_0000, 0, 0);

        run_sweep("zero", 0, 32'h1234_5678, 32'h1111_2222, 0, 0);

        for (int k = 0; k < 4; k++) begin
            e_arr[k] = rnd_s(32'h0100_0000);
            h_arr[k] = rnd_s(32'h0100_0000);
        end
        run_sweep("inj_start", 4, 32'h0000_C000, 32'h0000_4000, 0, 1);

        for (int s = 0; s < 8; s++) begin
            int n;
            logic [31:0] ca;
            logic [31:0] cb;
            n = $urandom_range(1, 12);
            rdy_mode = 2;
            if (s < 6) begin
                ca = rnd_s(32'h0002_0000);
                cb = rnd_s(32'h0002_0000);
                for (int k = 0; k < n; k++) begin
                    e_arr[k] = rnd_s(32'h03E8_0000);
                    h_arr[k] = rnd_s(32'h03E8_0000);
                end
            end else begin
                ca = $urandom;
                cb = $urandom;
                for (int k = 0; k < n; k++) begin
                    e_arr[k] = $urandom;
                    h_arr[k] = $urandom;
                end
            end
            run_sweep($sformatf("rand%0d", s), n, ca, cb, 1, 0);
        end
        rdy_mode = 0;

        // Abort a 5-cell sweep after two cells, then run a clean 3-cell sweep.
        for (int k = 0; k < 5; k++) begin
            e_arr[k] = rnd_s(32'h0010_0000);
            h_arr[k] = rnd_s(32'h0010_0000);
        end
        pulse_start(5, 32'h0001_8000, 32'h0000_6000);
        send_cell(0, 0);
        send_cell(1, 0);
        #2;
        RST_N = 1'b0;
        #1;
        check_zero_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        ov0 = ov_total;
        repeat (10) @(posedge CLK);
        #1;
        check("no_output_after_reset", 64'(ov_total - ov0), 64'd0);
        for (int k = 0; k < 3; k++) begin
            e_arr[k] = rnd_s(32'h0010_0000);
            h_arr[k] = rnd_s(32'h0010_0000);
        end
        run_sweep("post_reset", 3, 32'h0001_8000, 32'h0000_6000, 0, 0);

        check("done_max_len", 64'(done_maxlen), 64'd1);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench exceeded time limit, %0d failures so far", fails);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
